// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve
// Resolves conditional and unconditional branches in EX from the ALU flags,
// flags mispredictions against the direction chosen at fetch, and trains a
// table of 2-bit saturating counters that supplies the fetch-stage prediction.
// Two saturating performance counters track resolved branches and mispredictions.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   if_pc / pred_taken    fetch lookup PC and predicted direction (table MSB)
//   ex_valid, ex_stall    EX instruction valid / EX held (no state update)
//   br_instr, func3       instruction class (11 B-type, 01 J-type, x0 other), condition
//   ex_pc, ex_pred_taken  EX PC (table update index) and prediction made at fetch
//   z, c, n, v            ALU flags of rs1-rs2 (c = 1 means no borrow)
//   cnt_clr               clears both performance counters
//   br_taken, mispredict  resolved direction and misprediction flag
//   br_cnt, mispred_cnt   resolved-branch and misprediction counts
module branch_predict_resolve #(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [1:0]       br_instr,
    input  logic [2:0]       func3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic             z,
    input  logic             c,
    input  logic             n,
    input  logic             v,
    input  logic             cnt_clr,
    output logic             br_taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          bht_q [ENTRIES];
    logic [1:0]          bht_d [ENTRIES];
    logic [CNT_W-1:0]    br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]    mispred_cnt_q, mispred_cnt_d;

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic                cond;
    logic                is_branch;
    logic                upd;
    logic [1:0]          entry;

    // Only the word-aligned index bits address the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0],
                              ex_pc[XLEN-1:IDX_BITS+2], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];

    // Reset table value is 01, so a lookup during reset reads as not-taken.
    assign pred_taken = rst_n & bht_q[if_idx][1];

    always_comb begin
        cond = 1'b0;
        unique case (func3)
            3'b000:  cond = z;
            3'b001:  cond = ~z;
            3'b100:  cond = n ^ v;
            3'b101:  cond = ~(n ^ v);
            3'b110:  cond = ~c;
            3'b111:  cond = c;
            default: cond = 1'b0;
        endcase
    end

    assign is_branch  = rst_n & ex_valid & br_instr[0];
    assign br_taken   = is_branch & (br_instr[1] ? cond : 1'b1);
    assign mispredict = is_branch & (br_taken != ex_pred_taken);
    assign upd        = is_branch & ~ex_stall;

    always_comb begin
        bht_d = bht_q;
        entry = bht_q[ex_idx];
        if (upd) begin
            if (br_taken && entry != 2'b11) begin
                bht_d[ex_idx] = entry + 2'd1;
            end else if (!br_taken && entry != 2'b00) begin
                bht_d[ex_idx] = entry - 2'd1;
            end
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_comb begin
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (cnt_clr) begin
            br_cnt_d      = '0;
            mispred_cnt_d = '0;
        end else if (upd) begin
            if (br_cnt_q != '1) begin
                br_cnt_d = br_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (mispredict && mispred_cnt_q != '1) begin
                mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            bht_q         <= bht_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Testbench for branch_predict_resolve: directed scenarios followed by random
// stimulus, all checked against a behavioural model of the predictor table,
// the branch conditions and the saturating counters.
module tb_branch_predict_resolve;

    localparam int XLEN     = 32;
    localparam int IDX_BITS = 6;
    localparam int CNT_W    = 4;
    localparam int ENTRIES  = 64;
    localparam int CNT_MAX  = 15;

    logic             clk;
    logic             rst_n;
    logic [XLEN-1:0]  if_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic             ex_stall;
    logic [1:0]       br_instr;
    logic [2:0]       func3;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_pred_taken;
    logic             z, c, n, v;
    logic             cnt_clr;
    logic             br_taken;
    logic             mispredict;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    branch_predict_resolve #(
        .XLEN(XLEN), .IDX_BITS(IDX_BITS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .br_instr(br_instr),
        .func3(func3), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .z(z), .c(c), .n(n), .v(v), .cnt_clr(cnt_clr),
        .br_taken(br_taken), .mispredict(mispredict),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state
    int m_bht [ENTRIES];
    int m_br;
    int m_mp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pc_index(input logic [XLEN-1:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    // Branch direction from the architectural meaning of each condition.
    function automatic bit ref_taken();
        bit eq, lt_s, lt_u;
        if (!rst_n || !ex_valid || !br_instr[0]) return 1'b0;
        if (!br_instr[1]) return 1'b1;
        eq   = z;
        lt_s = (n != v);
        lt_u = !c;
        case (func3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt_s;
            3'd5: return !lt_s;
            3'd6: return lt_u;
            3'd7: return !lt_u;
            default: return 1'b0;
        endcase
    endfunction

    // Inputs are set at a falling edge; comb outputs checked, then one clock,
    // then registered state checked at the next falling edge.
    task automatic step();
        bit exp_t, exp_m, ev;
        int idx;
        #1;
        exp_t = ref_taken();
        exp_m = rst_n && ex_valid && br_instr[0] && (exp_t != ex_pred_taken);
        chk("br_taken", br_taken, exp_t);
        chk("mispredict", mispredict, exp_m);
        chk("pred_taken", pred_taken, rst_n ? (m_bht[pc_index(if_pc)] >= 2) : 0);
        ev  = rst_n && ex_valid && !ex_stall && br_instr[0];
        idx = pc_index(ex_pc);
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
            m_br = 0;
            m_mp = 0;
        end else begin
            if (ev) m_bht[idx] = exp_t ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                                       : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
            if (cnt_clr) begin
                m_br = 0;
                m_mp = 0;
            end else if (ev) begin
                m_br = (m_br < CNT_MAX) ? m_br + 1 : CNT_MAX;
                if (exp_m) m_mp = (m_mp < CNT_MAX) ? m_mp + 1 : CNT_MAX;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("br_cnt", br_cnt, m_br);
        chk("mispred_cnt", mispred_cnt, m_mp);
    endtask

    task automatic set_in(input bit vld, input bit stl, input logic [1:0] cls,
                          input logic [2:0] f3, input logic [3:0] flags,
                          input logic [31:0] epc, input logic [31:0] ipc, input bit pt);
        ex_valid = vld; ex_stall = stl; br_instr = cls; func3 = f3;
        {z, c, n, v} = flags; ex_pc = epc; if_pc = ipc; ex_pred_taken = pt;
    endtask

    initial begin
        int exp_seq [4];
        exp_seq = '{2, 3, 3, 3};
        for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
        m_br = 0; m_mp = 0;
        rst_n = 1'b0; cnt_clr = 1'b0;
        set_in(0, 0, 2'b00, 3'd0, 4'h0, 32'h0, 32'h0, 0);
        @(negedge clk);

        // Reset with a would-be event present: outputs forced low.
        set_in(1, 0, 2'b01, 3'd0, 4'h0, 32'h40, 32'h40, 0);
        step();
        step();
        rst_n = 1'b1;
        chk("bht16_after_reset", dut.bht_q[16], 2'd1);

        // Truth table (stalled, so no state change): all conditions x all flags.
        for (int f = 0; f < 8; f++) begin
            for (int fl = 0; fl < 16; fl++) begin
                set_in(1, 1, 2'b11, 3'(f), 4'(fl), 32'h80, 32'h80, 1'($urandom));
                step();
            end
        end
        // Non-branch class with stall low: nothing resolves.
        set_in(1, 0, 2'b10, 3'd0, 4'h8, 32'h40, 32'h40, 1);
        step();

        // Training: four taken BEQ at 0x40.
        for (int k = 0; k < 4; k++) begin
            set_in(1, 0, 2'b11, 3'd0, 4'h8, 32'h40, 32'h40, 0);
            step();
            chk("bht16_train", dut.bht_q[16], exp_seq[k]);
            set_in(0, 0, 2'b00, 3'd0, 4'h0, 32'h0, 32'h40, 0);
            #1 chk("pred_after_train", pred_taken, 1);
        end

        // Jump predicted not-taken.
        set_in(1, 0, 2'b01, 3'd0, 4'h0, 32'h200, 32'h200, 0);
        #1 chk("jal_mispredict", mispredict, 1);
        step();

        // Stalled valid branch leaves everything alone.
        set_in(1, 1, 2'b11, 3'd1, 4'h0, 32'h40, 32'h40, 0);
        step();
        chk("bht16_stall", dut.bht_q[16], 2'd3);

        // Aliasing: 0x140 maps onto the same entry as 0x40.
        set_in(1, 0, 2'b11, 3'd1, 4'h8, 32'h140, 32'h40, 1);
        step();
        chk("bht16_alias", dut.bht_q[16], 2'd2);

        // Counter saturation then clear with a simultaneous event.
        for (int k = 0; k < 20; k++) begin
            set_in(1, 0, 2'b01, 3'd0, 4'h0, 32'h300, 32'h300, 0);
            step();
        end
        chk("br_cnt_sat", br_cnt, 4'hF);
        chk("mp_cnt_sat", mispred_cnt, 4'hF);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("br_cnt_clr", br_cnt, 0);

        // Train 0x40 to 11, then reset with a concurrent event.
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 2'b01, 3'd0, 4'h0, 32'h40, 32'h40, 1);
            step();
        end
        chk("bht16_pre_reset", dut.bht_q[16], 2'd3);
        rst_n = 1'b0;
        set_in(1, 0, 2'b11, 3'd0, 4'h8, 32'h40, 32'h40, 0);
        step();
        rst_n = 1'b1;
        chk("bht16_reset", dut.bht_q[16], 2'd1);

        // Random traffic over a handful of indices, with aliasing upper bits.
        for (int k = 0; k < 600; k++) begin
            logic [31:0] epc;
            epc = ($urandom & 32'h0000_0F0C) | ($urandom_range(0, 3));
            set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                   2'($urandom), 3'($urandom), 4'($urandom), epc,
                   ($urandom_range(0, 1) != 0) ? epc : ($urandom & 32'h0000_0FFF),
                   1'($urandom));
            cnt_clr = ($urandom_range(0, 40) == 0);
            rst_n   = ($urandom_range(0, 150) != 0);
            step();
        end
        rst_n = 1'b1; cnt_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_resolve.md
BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC width in bits.
REQ-002 SHALL have parameter IDX_BITS, default 6, meaning BHT index width; the table holds 2^IDX_BITS entries.
REQ-003 SHALL have parameter CNT_W, default 32, meaning performance-counter width.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  in  1  meaning reset; reset is synchronous and active-low.
REQ-006 SHALL have port if_pc  in  XLEN  meaning fetch-stage PC for the prediction lookup.
REQ-007 SHALL have port pred_taken  out  1  meaning the fetch-stage prediction, equal to the MSB of BHT[if_pc[IDX_BITS+1:2]].
REQ-008 SHALL have port ex_valid  in  1  meaning the EX-stage instruction is valid; high one cycle per instruction.
REQ-009 SHALL have port ex_stall  in  1  meaning EX is held; state updates are suppressed.
REQ-010 SHALL have port br_instr  in  2  meaning instruction class: 11 = B-type, 01 = J-type, x0 = non-branch.
REQ-011 SHALL have port func3  in  3  meaning the B-type condition select.
REQ-012 SHALL have port ex_pc  in  XLEN  meaning the PC of the EX instruction, used for the BHT update index.
REQ-013 SHALL have port ex_pred_taken  in  1  meaning the prediction made at fetch, piped down to EX.
REQ-014 SHALL have port z, c, n, v  in  1 each  meaning ALU flags of rs1-rs2: zero, carry (1 = no borrow), negative, signed overflow.
REQ-015 SHALL have port cnt_clr  in  1  meaning synchronous clear of both performance counters.
REQ-016 SHALL have port br_taken  out  1  meaning the resolved branch decision.
REQ-017 SHALL have port mispredict  out  1  meaning the resolved direction differs from ex_pred_taken.
REQ-018 SHALL have ports br_cnt and mispred_cnt  out  CNT_W each  meaning resolved-branch and misprediction counts.

Function
REQ-019 br_taken SHALL be combinational and SHALL be 0 when br_instr[0]=0 or ex_valid=0.
REQ-020 br_taken SHALL be 1 for J-type.
REQ-021 For B-type, br_taken SHALL be: 000 BEQ z; 001 BNE ~z; 100 BLT n^v; 101 BGE ~(n^v); 110 BLTU ~c; 111 BGEU c; 010/011 forced 0.
REQ-022 mispredict SHALL be combinational and equal ex_valid & br_instr[0] & (br_taken != ex_pred_taken).
REQ-023 An update event SHALL be ex_valid & ~ex_stall & br_instr[0] & rst_n.
REQ-024 The BHT SHALL hold 2-bit saturating counters; on an update event, entry ex_pc[IDX_BITS+1:2] SHALL increment (saturating at 11) if br_taken, else decrement (saturating at 00).
REQ-025 Updates SHALL be written at the clock edge following the event, so latency is one cycle.
REQ-026 pred_taken SHALL have no bypass: a same-cycle lookup and update to one index SHALL return the pre-update value.
REQ-027 br_cnt SHALL increment on every update event.
REQ-028 mispred_cnt SHALL increment on every update event with mispredict=1.
REQ-029 Both counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-030 cnt_clr SHALL zero both counters, taking priority over a same-cycle increment; it SHALL NOT affect the BHT.
REQ-031 ex_stall=1 SHALL leave the BHT and counters unchanged, while br_taken and mispredict still reflect the inputs.

Reset
REQ-032 When rst_n=0 at a clock edge, all BHT entries SHALL be set to 01 (weakly not-taken) in that single cycle, and br_cnt and mispred_cnt SHALL be set to 0.
REQ-033 While rst_n=0, br_taken and mispredict SHALL be forced to 0, and pred_taken SHALL read the reset BHT value, giving 0.
REQ-034 A reset mid-operation SHALL discard any concurrent update event.

Verification
REQ-035 Truth table: all six func3 codes crossed with all z/c/n/v combinations, B-type -> br_taken matches REQ-021; func3=010 -> 0.
REQ-036 Training: four taken BEQ (z=1) at ex_pc=0x40 -> BHT[16] 01->10->11->11; pred_taken=1 at if_pc=0x40 from the cycle after the first update.
REQ-037 Mispredict and counters: J-type with ex_pred_taken=0 -> mispredict=1; next cycle br_cnt=1, mispred_cnt=1.
REQ-038 Stall and aliasing: ex_stall=1 with a valid branch -> no BHT or counter change; ex_pc=0x40 and 0x140 with IDX_BITS=6 update the same entry.
REQ-039 Saturation and clear: preload counters to all-ones, apply an event -> values hold; assert cnt_clr with a simultaneous event -> both counters 0.
REQ-040 Reset: train an entry to 11, drop rst_n for one cycle with a concurrent event -> entry 01, counters 0, outputs 0 during reset.
